// File: rtl/mdu_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 encodings,
// FSM state encoding and the default operand width / iteration count.
package mdu_pkg;

  localparam int MDU_XLEN = 32;
  localparam int MDU_ITER = 32;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_conv.sv
// Conditional two's-complement negation. Used both to take the magnitude of
// signed operands and to restore the sign of products, quotients and remainders.
module mdu_sign_conv #(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// registered single-cycle write toward the register file. Define
// MDU_FAST_MUL_EN to compute multiplies combinationally in one CALC cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN,
  parameter int ITER = MDU_ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            w_en,
  output logic [4:0]      w_addr,
  output logic [XLEN-1:0] w_data
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  mdu_state_e state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        addr_q, addr_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, quot_q, quot_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic              busy_q, busy_d, w_en_q, w_en_d;
  logic [4:0]        w_addr_q, w_addr_d;
  logic [XLEN-1:0]   w_data_q, w_data_d;

  // Operand magnitudes; MULHSU treats rs2 as unsigned.
  logic            in_signed_a, in_signed_b, div_by_zero;
  logic [XLEN-1:0] abs_a, abs_b;

  assign in_signed_a = (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
                       (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
  assign in_signed_b = (funct3 == MDU_MULH) || (funct3 == MDU_DIV) ||
                       (funct3 == MDU_REM);
  assign div_by_zero = funct3[2] && (rs2_data == '0);

  mdu_sign_conv #(.W(XLEN)) u_abs_a (
    .data_i (rs1_data),
    .neg_i  (in_signed_a & rs1_data[XLEN-1]),
    .data_o (abs_a)
  );

  mdu_sign_conv #(.W(XLEN)) u_abs_b (
    .data_i (rs2_data),
    .neg_i  (in_signed_b & rs2_data[XLEN-1]),
    .data_o (abs_b)
  );

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_step;
  logic [XLEN+1:0]   rem_diff;
  logic [XLEN:0]     rem_step;
  logic [XLEN-1:0]   quot_step;
  logic              last;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_step = {mul_sum, prod_q[XLEN-1:1]};
    rem_diff  = {rem_q, quot_q[XLEN-1]} - {2'b00, b_q};
    if (rem_diff[XLEN+1]) begin
      rem_step  = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
      quot_step = {quot_q[XLEN-2:0], 1'b0};
    end else begin
      rem_step  = rem_diff[XLEN:0];
      quot_step = {quot_q[XLEN-2:0], 1'b1};
    end
    last = (cnt_q == LAST);
`ifdef MDU_FAST_MUL_EN
    if (!op_q[2]) begin
      prod_step = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
      last      = 1'b1;
    end
`endif
  end

  // Sign restoration is applied to the final step's result so the write
  // data is ready in the same edge that ends CALC.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_raw, div_fix, result;
  logic              div_neg;

  assign div_raw = op_q[1] ? rem_step[XLEN-1:0] : quot_step;
  assign div_neg = op_q[1] ? sign_a_q : (sign_a_q ^ sign_b_q);

  mdu_sign_conv #(.W(2*XLEN)) u_neg_prod (
    .data_i (prod_step),
    .neg_i  (sign_a_q ^ sign_b_q),
    .data_o (prod_fix)
  );

  mdu_sign_conv #(.W(XLEN)) u_neg_div (
    .data_i (div_raw),
    .neg_i  (div_neg),
    .data_o (div_fix)
  );

  assign result = op_q[2] ? div_fix :
                  (op_q == MDU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    quot_d   = quot_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = funct3;
          addr_d   = rd_addr;
          sign_a_d = in_signed_a & rs1_data[XLEN-1];
          sign_b_d = in_signed_b & rs2_data[XLEN-1];
          a_d      = abs_a;
          b_d      = abs_b;
          quot_d   = abs_a;
          prod_d   = {{XLEN{1'b0}}, abs_b};
          rem_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          if (div_by_zero) begin
            state_d  = DONE;
            w_en_d   = (rd_addr != 5'd0);
            w_addr_d = rd_addr;
            w_data_d = funct3[1] ? rs1_data : '1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prod_d = prod_step;
        quot_d = quot_step;
        rem_d  = rem_step;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          state_d  = DONE;
          w_en_d   = (addr_q != 5'd0);
          w_addr_d = addr_q;
          w_data_d = result;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      quot_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quot_q   <= quot_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign busy   = busy_q;
  assign w_en   = w_en_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

endmodule
